// File: rtl/fastreadout_pkg.sv
// rtl/fastreadout_pkg.sv - shared state encoding and defaults for the fast-readout sequencers
package fastreadout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        INJECT,
        DELAY,
        TRIGGER,
        WAIT_RO,
        GAP,
        DONE
    } seq_state_t;

    localparam int ARM_TICKS_DEFAULT = 4;

    // A programmed pulse width of zero still yields a one-tick pulse.
    function automatic logic [7:0] pulse_ticks(input logic [7:0] width);
        return (width == 8'd0) ? 8'd1 : width;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - loadable down-counter of ts_tick pulses with a terminal flag
module tick_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             ts_tick,
    output logic             terminal
);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_value;
        end else if (ts_tick && remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Terminal on the tick that consumes the last count; a load of 0 behaves like 1.
    assign terminal = ts_tick && (remaining[CNT_W-1:1] == '0);

endmodule

// File: rtl/inj_trig_sequencer.sv
// rtl/inj_trig_sequencer.sv - timestamp-tick paced injection/trigger run sequencer
module inj_trig_sequencer
    import fastreadout_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int ARM_TICKS = ARM_TICKS_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             ts_tick,
    input  logic [CNT_W-1:0] inj_count,
    input  logic [CNT_W-1:0] inj_period,
    input  logic [7:0]       inj_width,
    input  logic [7:0]       trig_width,
    input  logic [CNT_W-1:0] trig_delay,
    input  logic             readout_busy,
    output logic             ts_enable,
    output logic             injection,
    output logic             trigger,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             overrun,
    output logic [CNT_W-1:0] inj_done_cnt
);

    seq_state_t state, next_state;

    logic [CNT_W-1:0] cfg_count;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_delay;
    logic [7:0]       cfg_inj_width;
    logic [7:0]       cfg_trig_width;

    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W:0]   period_next;
    logic             period_elapsed;
    logic             period_reached;

    logic             run_start;
    logic             run_abort;
    logic             set_overrun;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_terminal;

    assign run_start      = (state == IDLE) && start && !abort;
    assign run_abort      = (state != IDLE) && (state != DONE) && abort;
    assign period_next    = {1'b0, period_cnt} + (CNT_W+1)'(1);
    assign period_elapsed = (period_cnt >= cfg_period);
    assign period_reached = (period_next >= {1'b0, cfg_period});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        set_overrun = 1'b0;
        if (run_abort) begin
            next_state = DONE;
        end else begin
            case (state)
                IDLE:    if (run_start) next_state = ARM;
                ARM:     if (tmr_terminal) next_state = INJECT;
                INJECT:  if (tmr_terminal) next_state = DELAY;
                DELAY:   if (cfg_delay == '0 || tmr_terminal) next_state = TRIGGER;
                TRIGGER: if (tmr_terminal) next_state = WAIT_RO;
                WAIT_RO: begin
                    if (!readout_busy) begin
                        if (cfg_count != '0 && inj_done_cnt == cfg_count) begin
                            next_state = DONE;
                        end else begin
                            next_state = GAP;
                        end
                    end
                end
                GAP: begin
                    // Already past the period on entry: the sequence ran long.
                    if (period_elapsed) begin
                        set_overrun = 1'b1;
                        next_state  = INJECT;
                    end else if (ts_tick && period_reached) begin
                        next_state = INJECT;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    assign tmr_load = (next_state != state);

    always_comb begin
        tmr_value = '0;
        case (next_state)
            ARM:     tmr_value = CNT_W'(ARM_TICKS);
            INJECT:  tmr_value = CNT_W'(pulse_ticks(cfg_inj_width));
            DELAY:   tmr_value = cfg_delay;
            TRIGGER: tmr_value = CNT_W'(pulse_ticks(cfg_trig_width));
            default: tmr_value = '0;
        endcase
    end

    tick_counter #(
        .CNT_W(CNT_W)
    ) u_state_timer (
        .clock     (clock),
        .reset     (reset),
        .load      (tmr_load),
        .load_value(tmr_value),
        .ts_tick   (ts_tick),
        .terminal  (tmr_terminal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_count      <= '0;
            cfg_period     <= '0;
            cfg_delay      <= '0;
            cfg_inj_width  <= '0;
            cfg_trig_width <= '0;
            period_cnt     <= '0;
            inj_done_cnt   <= '0;
            overrun        <= 1'b0;
            aborted        <= 1'b0;
            ts_enable      <= 1'b0;
            injection      <= 1'b0;
            trigger        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            if (run_start) begin
                cfg_count      <= inj_count;
                cfg_period     <= inj_period;
                cfg_delay      <= trig_delay;
                cfg_inj_width  <= inj_width;
                cfg_trig_width <= trig_width;
                inj_done_cnt   <= '0;
                overrun        <= 1'b0;
                aborted        <= 1'b0;
            end else begin
                if (state == INJECT && next_state == DELAY) begin
                    inj_done_cnt <= inj_done_cnt + CNT_W'(1);
                end
                if (set_overrun) begin
                    overrun <= 1'b1;
                end
                if (run_abort) begin
                    aborted <= 1'b1;
                end
            end

            // Period is measured from each injection rising edge and saturates.
            if (run_start || (next_state == INJECT && state != INJECT)) begin
                period_cnt <= '0;
            end else if (state != IDLE && ts_tick && period_cnt != '1) begin
                period_cnt <= period_cnt + CNT_W'(1);
            end

            injection <= (next_state == INJECT);
            trigger   <= (next_state == TRIGGER);
            ts_enable <= (next_state != IDLE) && (next_state != DONE);
            busy      <= (next_state != IDLE);
            done      <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_inj_trig_sequencer.sv
// tb/tb_inj_trig_sequencer.sv - directed self-checking bench for inj_trig_sequencer
module tb_inj_trig_sequencer;

    localparam int CNT_W = 16;

    logic             clock;
    logic             reset;
    logic             start;
    logic             abort;
    logic             ts_tick;
    logic [CNT_W-1:0] inj_count;
    logic [CNT_W-1:0] inj_period;
    logic [7:0]       inj_width;
    logic [7:0]       trig_width;
    logic [CNT_W-1:0] trig_delay;
    logic             readout_busy;
    logic             ts_enable;
    logic             injection;
    logic             trigger;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             overrun;
    logic [CNT_W-1:0] inj_done_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int tick_num = 0;
    int cyc_num = 0;
    int done_cnt = 0;
    int start_tick = 0;
    int tick_div = 0;
    int inj_rise_t[$], inj_fall_t[$], trig_rise_t[$], trig_fall_t[$];
    int inj_rise_c[$], inj_fall_c[$], trig_rise_c[$], trig_fall_c[$];
    logic inj_q = 1'b0;
    logic trg_q = 1'b0;

    inj_trig_sequencer #(
        .CNT_W    (CNT_W),
        .ARM_TICKS(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .ts_tick     (ts_tick),
        .inj_count   (inj_count),
        .inj_period  (inj_period),
        .inj_width   (inj_width),
        .trig_width  (trig_width),
        .trig_delay  (trig_delay),
        .readout_busy(readout_busy),
        .ts_enable   (ts_enable),
        .injection   (injection),
        .trigger     (trigger),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .overrun     (overrun),
        .inj_done_cnt(inj_done_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One ts_tick every fourth clock.
    initial begin
        ts_tick = 1'b0;
        forever begin
            @(negedge clock);
            tick_div = (tick_div == 3) ? 0 : tick_div + 1;
            ts_tick  = (tick_div == 0);
        end
    end

    // Edge log stamped with tick and cycle numbers.
    initial begin
        forever begin
            @(posedge clock);
            cyc_num++;
            if (ts_tick) tick_num++;
            #1;
            if (injection && !inj_q) begin inj_rise_t.push_back(tick_num); inj_rise_c.push_back(cyc_num); end
            if (!injection && inj_q) begin inj_fall_t.push_back(tick_num); inj_fall_c.push_back(cyc_num); end
            if (trigger && !trg_q) begin trig_rise_t.push_back(tick_num); trig_rise_c.push_back(cyc_num); end
            if (!trigger && trg_q) begin trig_fall_t.push_back(tick_num); trig_fall_c.push_back(cyc_num); end
            if (done) done_cnt++;
            inj_q = injection;
            trg_q = trigger;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -9999;
    endfunction

    function automatic int ev_count(input int which);
        case (which)
            0:       return done_cnt;
            1:       return inj_rise_t.size();
            2:       return inj_fall_t.size();
            3:       return trig_fall_t.size();
            4:       return tick_num;
            5:       return trig_rise_t.size();
            default: return 0;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic wait_ev(input string tag, input int which, input int n, input int max_cyc);
        int k = 0;
        while (ev_count(which) < n && k < max_cyc) begin
            step(1);
            k++;
        end
        check(tag, 32'(ev_count(which) >= n), 1);
    endtask

    task automatic clear_log();
        inj_rise_t.delete(); inj_fall_t.delete(); trig_rise_t.delete(); trig_fall_t.delete();
        inj_rise_c.delete(); inj_fall_c.delete(); trig_rise_c.delete(); trig_fall_c.delete();
        done_cnt = 0;
    endtask

    task automatic run(input int cnt, input int per, input int iw, input int td, input int tw);
        inj_count  = CNT_W'(cnt);
        inj_period = CNT_W'(per);
        inj_width  = 8'(iw);
        trig_delay = CNT_W'(td);
        trig_width = 8'(tw);
        clear_log();
        step(1);
        while (ts_tick) step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        start_tick = tick_num;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; readout_busy = 1'b0;
        inj_count = '0; inj_period = '0; inj_width = '0; trig_width = '0; trig_delay = '0;
        step(3);
        check("rst_injection", 32'(injection), 0);
        check("rst_trigger", 32'(trigger), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ts_enable", 32'(ts_enable), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cnt", 32'(inj_done_cnt), 0);
        reset = 1'b0;
        step(2);
        check("idle_busy", 32'(busy), 0);

        // Nominal three-injection run; config and start changes mid-run are ignored.
        run(3, 100, 2, 10, 8);
        check("A_busy", 32'(busy), 1);
        check("A_ts_enable", 32'(ts_enable), 1);
        inj_period = 16'd7; inj_width = 8'd50; trig_delay = 16'd1; inj_count = 16'd1;
        wait_ev("A_first_inj", 1, 1, 100);
        start = 1'b1; step(1); start = 1'b0;
        wait_ev("A_done", 0, 1, 2000);
        check("A_done_pulse", 32'(done), 1);
        step(1);
        check("A_n_inj", inj_rise_t.size(), 3);
        check("A_n_trig", trig_rise_t.size(), 3);
        check("A_arm_ticks", qget(inj_rise_t, 0) - start_tick, 4);
        check("A_period1", qget(inj_rise_t, 1) - qget(inj_rise_t, 0), 100);
        check("A_period2", qget(inj_rise_t, 2) - qget(inj_rise_t, 1), 100);
        check("A_inj_width", qget(inj_fall_t, 0) - qget(inj_rise_t, 0), 2);
        for (int i = 0; i < 3; i++) check("A_trig_delay", qget(trig_rise_t, i) - qget(inj_fall_t, i), 10);
        check("A_trig_width", qget(trig_fall_t, 0) - qget(trig_rise_t, 0), 8);
        check("A_cnt", 32'(inj_done_cnt), 3);
        check("A_aborted", 32'(aborted), 0);
        check("A_overrun", 32'(overrun), 0);
        check("A_idle_busy", 32'(busy), 0);
        check("A_idle_done", 32'(done), 0);
        check("A_idle_ts_enable", 32'(ts_enable), 0);
        step(10);
        check("A_cnt_hold", 32'(inj_done_cnt), 3);

        // Period shorter than the sequence: overrun, back-to-back injections.
        run(3, 5, 2, 10, 8);
        wait_ev("B_done", 0, 1, 1000);
        step(1);
        check("B_overrun", 32'(overrun), 1);
        check("B_spacing1", qget(inj_rise_t, 1) - qget(inj_rise_t, 0), 20);
        check("B_spacing2", qget(inj_rise_t, 2) - qget(inj_rise_t, 1), 20);
        check("B_gap_clocks", qget(inj_rise_c, 1) - qget(trig_fall_c, 0), 2);
        check("B_cnt", 32'(inj_done_cnt), 3);

        // Readout busy holds WAIT_RO 50 ticks past the first trigger.
        readout_busy = 1'b1;
        run(2, 100, 2, 10, 8);
        check("C_overrun_cleared", 32'(overrun), 0);
        wait_ev("C_trig_fall", 3, 1, 400);
        wait_ev("C_hold", 4, qget(trig_fall_t, 0) + 50, 400);
        check("C_no_second_inj", inj_rise_t.size(), 1);
        check("C_busy_holding", 32'(busy), 1);
        check("C_no_done", done_cnt, 0);
        readout_busy = 1'b0;
        wait_ev("C_done", 0, 1, 1000);
        step(1);
        check("C_period", qget(inj_rise_t, 1) - qget(inj_rise_t, 0), 100);
        check("C_overrun", 32'(overrun), 0);
        check("C_cnt", 32'(inj_done_cnt), 2);

        // Unlimited run aborted in the DELAY after the 7th injection.
        run(0, 30, 1, 10, 2);
        wait_ev("D_7th_fall", 2, 7, 3000);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("D_injection", 32'(injection), 0);
        check("D_trigger", 32'(trigger), 0);
        check("D_ts_enable", 32'(ts_enable), 0);
        check("D_done", 32'(done), 1);
        check("D_aborted", 32'(aborted), 1);
        check("D_busy", 32'(busy), 1);
        check("D_cnt", 32'(inj_done_cnt), 7);
        check("D_n_trig", trig_rise_t.size(), 6);
        step(1);
        check("D_done_one_cycle", 32'(done), 0);
        check("D_idle", 32'(busy), 0);
        check("D_cnt_hold", 32'(inj_done_cnt), 7);

        // Zero widths give one-tick pulses; zero delay triggers on the next clock.
        run(1, 10, 0, 0, 0);
        wait_ev("E_done", 0, 1, 300);
        step(1);
        check("E_inj_width", qget(inj_fall_t, 0) - qget(inj_rise_t, 0), 1);
        check("E_trig_width", qget(trig_fall_t, 0) - qget(trig_rise_t, 0), 1);
        check("E_delay0_clocks", qget(trig_rise_c, 0) - qget(inj_fall_c, 0), 1);
        check("E_cnt", 32'(inj_done_cnt), 1);

        // Start with abort in IDLE is ignored.
        clear_log();
        start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        check("F_busy", 32'(busy), 0);
        check("F_ts_enable", 32'(ts_enable), 0);
        step(4);
        check("F_still_idle", 32'(busy), 0);
        check("F_no_done", done_cnt, 0);

        // Asynchronous reset mid-TRIGGER clears everything; no run resumes.
        run(1, 100, 2, 3, 8);
        wait_ev("F_trig", 5, 1, 200);
        check("F_trig_high", 32'(trigger), 1);
        #2;
        reset = 1'b1;
        #1;
        check("F_rst_trigger", 32'(trigger), 0);
        check("F_rst_injection", 32'(injection), 0);
        check("F_rst_busy", 32'(busy), 0);
        check("F_rst_ts_enable", 32'(ts_enable), 0);
        check("F_rst_done", 32'(done), 0);
        check("F_rst_cnt", 32'(inj_done_cnt), 0);
        step(1);
        reset = 1'b0;
        clear_log();
        step(40);
        check("F_no_resume_busy", 32'(busy), 0);
        check("F_no_resume_inj", inj_rise_t.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inj_trig_sequencer.md
INJ_TRIG_SEQUENCER -- requirements
Module: inj_trig_sequencer

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of count/period/delay fields.
REQ-002 SHALL provide parameter ARM_TICKS, default 4, ts_tick pulses between run start and first injection.
REQ-003 clock  in  1  system clock.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 start  in  1  one-cycle run request.
REQ-006 abort  in  1  one-cycle run cancel.
REQ-007 ts_tick  in  1  one-cycle pulse per TS1 increment from timestamp generator.
REQ-008 inj_count  in  CNT_W  injections per run; 0 = unlimited until abort.
REQ-009 inj_period  in  CNT_W  ticks from one injection rising edge to the next.
REQ-010 inj_width / trig_width  in  8 each  pulse widths in ticks; 0 treated as 1.
REQ-011 trig_delay  in  CNT_W  ticks from injection falling edge to trigger rising edge.
REQ-012 readout_busy  in  1  readout still draining previous event.
REQ-013 ts_enable  out  1  enable to timestamp generator; high while run active.
REQ-014 injection / trigger  out  1 each  registered pulse outputs.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on run end; aborted  out  1  qualifies done.
REQ-017 overrun  out  1  sticky: period elapsed before sequence reached GAP.
REQ-018 inj_done_cnt  out  CNT_W  injections completed this run.

Function
REQ-019 States SHALL be IDLE, ARM, INJECT, DELAY, TRIGGER, WAIT_RO, GAP, DONE; all outputs registered.
REQ-020 Timed states SHALL count ts_tick pulses only; a state exits on the clock edge on which its final tick is counted.
REQ-021 IDLE: start with abort low SHALL latch all config inputs, clear inj_done_cnt, overrun, aborted, set ts_enable, enter ARM; config changes mid-run SHALL be ignored.
REQ-022 start while busy SHALL be ignored.
REQ-023 ARM: after ARM_TICKS ticks SHALL enter INJECT.
REQ-024 INJECT: injection high for inj_width ticks; on entry the period counter SHALL restart at 0; on exit inj_done_cnt SHALL increment.
REQ-025 DELAY: wait trig_delay ticks; trig_delay=0 SHALL go to TRIGGER on the next clock.
REQ-026 TRIGGER: trigger high for trig_width ticks, then WAIT_RO.
REQ-027 WAIT_RO: when readout_busy sampled low, enter DONE if inj_count!=0 and inj_done_cnt==inj_count, else GAP.
REQ-028 Period counter SHALL increment per tick from INJECT entry and saturate at all-ones.
REQ-029 GAP: enter INJECT when period counter >= inj_period; if already true on GAP entry, set overrun and enter INJECT on the next clock.
REQ-030 DONE: pulse done for one cycle, clear ts_enable, return to IDLE.
REQ-031 abort in any non-IDLE state SHALL force injection, trigger, ts_enable low on the next clock, pulse done with aborted=1, return to IDLE; abort wins over simultaneous start.
REQ-032 inj_done_cnt SHALL hold its final value in IDLE until the next start; unlimited mode SHALL wrap modulo 2^CNT_W.

Reset
REQ-033 reset SHALL force IDLE and zero every output and internal counter asynchronously.
REQ-034 reset release SHALL require a fresh start; no run resumes.

Structure
REQ-035 State encoding enum and ARM_TICKS default SHALL live in shared package fastreadout_pkg.
REQ-036 One sub-module, tick_counter (load, ts_tick-qualified count, terminal flag), SHALL be instantiated for state timing; period counter stays inline.

Verification
REQ-037 ts_tick every 4 clocks, inj_count=3, inj_period=100, inj_width=2, trig_delay=10, trig_width=8 -> 3 injection pulses 100 ticks apart, trigger 10 ticks after each injection fall, done after 3rd, inj_done_cnt=3.
REQ-038 inj_period=5 with inj_width=2, trig_delay=10 -> overrun=1, injections back-to-back via GAP exit next clock.
REQ-039 readout_busy held 50 ticks after first trigger -> GAP entry delayed 50 ticks, second injection at next tick where counter >= period.
REQ-040 inj_count=0, abort after 7th injection during DELAY -> outputs low next clock, done+aborted, inj_done_cnt=7.
REQ-041 start and abort same cycle in IDLE -> stays IDLE, busy=0; reset asserted mid-TRIGGER -> all outputs 0 immediately.
REQ-042 inj_width=0, trig_width=0 -> each pulse exactly 1 tick long.
